// File: rtl/line_pkg.sv
// line_pkg: screen geometry, arbiter states and line request types shared with the line drawer.
package line_pkg;
    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam int H_RES = 640;
    localparam int V_RES = 480;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, ACK} arb_state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } point_t;

    typedef struct packed {
        point_t p0;
        point_t p1;
        logic   color;
    } line_req_t;

    function automatic logic on_screen(input point_t p);
        return (p.x < X_W'(H_RES)) && (p.y < Y_W'(V_RES));
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter
    import line_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      idx,
    output logic            any
);
    always_comb begin
        idx = '0;
        // Scanning from the far end lets the closest hit to ptr overwrite the others.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NREQ])
                idx = 3'((int'(ptr) + i) % NREQ);
        end
        any = |req;
        gnt = any ? (NREQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/line_draw_arbiter.sv
// line_draw_arbiter: shares one Bresenham drawer among NREQ requesters with
// round-robin grants, screen range checks and a watchdog on the drawer.
module line_draw_arbiter
    import line_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1_048_576
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*X_W-1:0] req_x0,
    input  logic [NREQ*X_W-1:0] req_x1,
    input  logic [NREQ*Y_W-1:0] req_y0,
    input  logic [NREQ*Y_W-1:0] req_y1,
    input  logic [NREQ-1:0]     req_color,
    output logic [NREQ-1:0]     ack,
    output logic                ack_err,
    output logic                busy,
    output logic [2:0]          gnt_id,
    output logic                drw_start,
    output logic                drw_abort,
    output logic [X_W-1:0]      drw_x0,
    output logic [X_W-1:0]      drw_x1,
    output logic [Y_W-1:0]      drw_y0,
    output logic [Y_W-1:0]      drw_y1,
    output logic                drw_color,
    input  logic                drw_done
);
    localparam int CW = $clog2(TIMEOUT);

    arb_state_t      state;
    logic [2:0]      rr_ptr;
    logic [2:0]      idx;
    logic [2:0]      next_ptr;
    logic [NREQ-1:0] gnt_oh;
    logic            any;
    logic            legal;
    logic [CW-1:0]   cnt;
    line_req_t       cur;
    line_req_t       pick;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (gnt_oh),
        .idx (idx),
        .any (any)
    );

    always_comb begin
        pick.p0.x = req_x0[int'(idx)*X_W +: X_W];
        pick.p0.y = req_y0[int'(idx)*Y_W +: Y_W];
        pick.p1.x = req_x1[int'(idx)*X_W +: X_W];
        pick.p1.y = req_y1[int'(idx)*Y_W +: Y_W];
        pick.color = |(req_color & gnt_oh);
        legal = on_screen(pick.p0) && on_screen(pick.p1);
        next_ptr = (gnt_id == 3'(NREQ - 1)) ? 3'd0 : gnt_id + 3'd1;
    end

    assign drw_x0    = cur.p0.x;
    assign drw_y0    = cur.p0.y;
    assign drw_x1    = cur.p1.x;
    assign drw_y1    = cur.p1.y;
    assign drw_color = cur.color;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_id    <= '0;
            cur       <= '0;
            cnt       <= '0;
            ack       <= '0;
            ack_err   <= 1'b0;
            busy      <= 1'b0;
            drw_start <= 1'b0;
            drw_abort <= 1'b0;
        end else begin
            drw_start <= 1'b0;
            drw_abort <= 1'b0;
            ack       <= '0;
            ack_err   <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    cur    <= pick;
                    gnt_id <= idx;
                    busy   <= 1'b1;
                    if (legal) begin
                        drw_start <= 1'b1;
                        state     <= LAUNCH;
                    end else begin
                        ack     <= gnt_oh;
                        ack_err <= 1'b1;
                        state   <= ACK;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                // Abort decided as the count steps to TIMEOUT-1 so the registered pulse lands with the ack.
                WAIT: if (drw_done) begin
                    ack   <= NREQ'(1) << gnt_id;
                    state <= ACK;
                end else if (cnt == CW'(TIMEOUT - 2)) begin
                    drw_abort <= 1'b1;
                    ack       <= NREQ'(1) << gnt_id;
                    ack_err   <= 1'b1;
                    state     <= ACK;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                ACK: begin
                    rr_ptr <= next_ptr;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/line_draw_arbiter.md
# line_draw_arbiter

Shares a single Bresenham line-drawing core among NREQ requesters, such as a UI overlay, a test-pattern generator and a clear/animation sequencer. Each request carries one line's endpoints and colour. The block grants requesters round-robin and range-checks the endpoints against the 640x480 screen. It launches the drawer with a one-cycle start pulse, waits for its done pulse under a watchdog, and returns a one-cycle ack with an error flag to the requester.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 1_048_576, maximum WAIT cycles before abort; must be at least 2
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  NREQ  per-requester request level
- req_x0, req_x1  in  NREQ*10  packed endpoint x; requester i occupies bits [10i+9:10i]
- req_y0, req_y1  in  NREQ*9  packed endpoint y
- req_color  in  NREQ  pixel colour (1 = white, 0 = black)
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- ack_err  out  1  qualifies ack: 1 = rejected or aborted
- busy  out  1  high when state is not IDLE
- gnt_id  out  3  index of the current or last grant
- drw_start  out  1  one-cycle launch pulse to the drawer
- drw_abort  out  1  one-cycle pulse; the drawer must return to idle
- drw_x0, drw_x1  out  10  latched endpoints
- drw_y0, drw_y1  out  9
- drw_color  out  1
- drw_done  in  1  drawer completion pulse

## Operation
- States: IDLE, LAUNCH, WAIT, ACK.
- IDLE:
  - If any req is high, pick the first requester at or after rr_ptr, wrapping modulo NREQ.
  - Latch its coordinates and colour into the drw_* registers and set gnt_id.
  - If x0, x1 ≥ 640 or y0, y1 ≥ 480, set err and go to ACK. No drw_start is issued.
  - Otherwise go to LAUNCH.
- LAUNCH: assert drw_start, clear the watchdog counter, go to WAIT.
- WAIT:
  - drw_done: go to ACK with err=0.
  - Counter reaches TIMEOUT-1 without drw_done: assert drw_abort, go to ACK with err=1.
  - Otherwise increment the counter.
- ACK:
  - Assert ack[gnt_id] and drive ack_err=err.
  - Set rr_ptr to (gnt_id+1) mod NREQ and go to IDLE.
- Requesters hold req and operands until their ack. Dropping req after grant is ignored and the line completes.
- A requester re-arbitrates only after ack and must deassert req in the ack cycle or re-request.
- drw_done outside WAIT is ignored.
- drw_done and timeout in the same cycle: done wins, err=0, no abort.
- Zero-length lines (x0==x1, y0==y1) are legal and launched normally.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, gnt_id 0, err 0.
  - All drw_* outputs 0; ack, ack_err, busy, drw_start and drw_abort 0.
- Reset mid-operation returns to IDLE within one cycle. No ack or abort is issued; the drawer shares the reset.
- Req seen in IDLE at cycle t:
  - drw_start at t+1.
  - drw_done at cycle d gives ack at d+1.
  - The arbiter is back in IDLE at d+2.
- Rejected request: ack with ack_err at t+1.
- drw_* coordinates are stable from t+1 until the next grant.
- All outputs are registered.

## Structure
- Package line_pkg:
  - X_W=10, Y_W=9, H_RES=640, V_RES=480.
  - The arb_state_t enum.
  - Point and request struct typedefs shared with the line drawer.
- Sub-module rr_arbiter (NREQ):
  - Inputs req and ptr; outputs a one-hot grant and the index.
  - Purely combinational.
- The top level holds the FSM, operand registers and watchdog counter.

## Test plan
- Single request on req[1] with (0,0)-(10,5); drawer model returns done 12 cycles after start -> drw_start at t+1, drw_x1=10, then ack[1]=1, ack_err=0, one cycle after done.
- req[0], req[2] and req[3] all held high from reset -> grants in order 0, 2, 3, 0 with exactly one ack per line.
- Request with x1=640 -> no drw_start, ack with ack_err=1 at t+1, rr_ptr advances.
- Drawer never returns done, TIMEOUT=16 -> drw_abort 16 cycles after start, then ack with ack_err=1.
- drw_done on the same cycle the watchdog expires -> ack_err=0 and no drw_abort.
- reset asserted in WAIT -> next cycle busy=0 and all outputs 0; a request already pending is re-granted starting from requester 0.
